axi_burst_addr_gen: RTL and testbench

Per-beat address generator for AXI read/write bursts, used behind AR/AW channel acceptance in slave-side controllers. Accepts one burst command (address, length, size, burst type) per handshake and emits one beat descriptor per cycle under valid/ready backpressure, with beat address, byte-lane offset, beat index and last flag. Supports AXI3 and AXI4 length widths via parameter, and flags protocol-illegal commands so the consuming slave can answer SLVERR.

---
 rtl/axi_burst_addr_gen.sv | 179 +++++++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - per-beat AXI burst address generator (FIXED/INCR/WRAP)
// Optional protocol-error detection is compiled in when AXI_BURST_ERR_CHECK_EN is defined.
module axi_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 4,
  localparam int LANE_BITS = $clog2(DATA_WIDTH / 8),
  localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [LANE_W-1:0]     beat_lane,
  output logic [LEN_WIDTH-1:0]  beat_idx,
  output logic                  beat_last,
  output logic                  beat_err
);

  localparam logic IDLE  = 1'b0;
  localparam logic BURST = 1'b1;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic                  state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;

  logic                  beat_hs;
  logic                  cmd_hs;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] wrap_w;
  logic [ADDR_WIDTH-1:0] wrap_lo;
  logic [ADDR_WIDTH-1:0] wrap_nxt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  cmd_err;

  assign beat_hs   = (state_q == BURST) && beat_ready;
  assign cmd_ready = (state_q == IDLE) || (beat_hs && last_q);
  assign cmd_hs    = cmd_valid && cmd_ready;

  assign beat_valid = (state_q == BURST);
  assign beat_id    = id_q;
  assign beat_addr  = addr_q;
  assign beat_lane  = addr_q[LANE_W-1:0];
  assign beat_idx   = idx_q;
  assign beat_last  = last_q;

  // Next-beat address; reserved burst type follows the INCR path.
  always_comb begin
    step      = ONE << size_q;
    aligned   = addr_q & ~(step - ONE);
    wrap_w    = (ADDR_WIDTH'(len_q) + ONE) << size_q;
    wrap_lo   = start_q & ~(wrap_w - ONE);
    wrap_nxt  = addr_q + step;
    if (wrap_nxt == wrap_lo + wrap_w) begin
      wrap_nxt = wrap_lo;
    end
    next_addr = aligned + step;
    if (burst_q == BURST_FIXED) begin
      next_addr = addr_q;
    end else if (burst_q == BURST_WRAP) begin
      next_addr = wrap_nxt;
    end
  end

`ifdef AXI_BURST_ERR_CHECK_EN
  logic [ADDR_WIDTH-1:0] cmd_b;
  logic [ADDR_WIDTH-1:0] cmd_a;
  logic [ADDR_WIDTH-1:0] incr_end;
  int unsigned           len_ext;
  logic                  wrap_len_ok;

  always_comb begin
    cmd_b       = ONE << cmd_size;
    cmd_a       = cmd_addr & ~(cmd_b - ONE);
    incr_end    = cmd_a + (ADDR_WIDTH'(cmd_len) << cmd_size);
    len_ext     = 32'(cmd_len);
    wrap_len_ok = (len_ext == 1) || (len_ext == 3) || (len_ext == 7) || (len_ext == 15);
    cmd_err     = 1'b0;
    if (int'(cmd_size) > LANE_BITS) cmd_err = 1'b1;
    if (cmd_burst == 2'b11) cmd_err = 1'b1;
    if (cmd_burst == BURST_WRAP && (!wrap_len_ok || (cmd_addr & (cmd_b - ONE)) != '0)) cmd_err = 1'b1;
    if (cmd_burst == 2'b01 && incr_end[ADDR_WIDTH-1:12] != cmd_addr[ADDR_WIDTH-1:12]) cmd_err = 1'b1;
    if ((cmd_burst == BURST_FIXED || cmd_burst == BURST_WRAP) && len_ext > 15) cmd_err = 1'b1;
  end

  assign beat_err = err_q;
`else
  assign cmd_err  = 1'b0;
  assign beat_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    start_d = start_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    err_d   = err_q;
    if (beat_hs) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        idx_d  = idx_q + 1'b1;
        addr_d = next_addr;
        last_d = ((idx_q + 1'b1) == len_q);
      end
    end
    // A command accepted on the last beat reloads with no idle cycle.
    if (cmd_hs) begin
      state_d = BURST;
      id_d    = cmd_id;
      len_d   = cmd_len;
      size_d  = cmd_size;
      burst_d = cmd_burst;
      start_d = cmd_addr;
      addr_d  = cmd_addr;
      idx_d   = '0;
      last_d  = (cmd_len == '0);
      err_d   = cmd_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      start_q <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

`ifndef AXI_BURST_ERR_CHECK_EN
  logic unused_err;
  assign unused_err = err_q ^ err_d;
`endif

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// tb/tb_axi_burst_addr_gen.sv - scoreboard bench for axi_burst_addr_gen (AXI4 length width)
module tb_axi_burst_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic [2:0]  beat_lane;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        beat_err;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .LEN_WIDTH(8), .ID_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id), .beat_addr(beat_addr),
    .beat_lane(beat_lane), .beat_idx(beat_idx), .beat_last(beat_last), .beat_err(beat_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  lane;
    logic [7:0]  idx;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    pop_cyc[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  int    mode   = 0;
  logic  stalled = 1'b0;
  beat_t held;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    beat_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      beat_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Reference: expected beats of one command, straight from the burst rules.
  function automatic void model(input logic [3:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
    logic [31:0] b, a, w, lower, cur, nxt, ba;
    logic        err;
    beat_t       e;
    b     = 32'd1 << size;
    a     = addr & ~(b - 1);
    w     = b * (32'(len) + 1);
    lower = addr & ~(w - 1);
    err   = 1'b0;
`ifdef AXI_BURST_ERR_CHECK_EN
    if (size > 3) err = 1'b1;
    if (burst == 2'b11) err = 1'b1;
    if (burst == 2'b10 && (!(len == 1 || len == 3 || len == 7 || len == 15) || (addr % b) != 0)) err = 1'b1;
    if (burst == 2'b01 && ((a + 32'(len) * b) >> 12) != (addr >> 12)) err = 1'b1;
    if ((burst == 2'b00 || burst == 2'b10) && len > 15) err = 1'b1;
`endif
    cur = addr;
    for (int n = 0; n <= int'(len); n++) begin
      if (burst == 2'b00) ba = addr;
      else if (burst == 2'b10) ba = cur;
      else ba = (n == 0) ? addr : a + 32'(n) * b;
      nxt = cur + b;
      cur = (nxt == lower + w) ? lower : nxt;
      e.id = id; e.addr = ba; e.lane = ba[2:0]; e.idx = 8'(n);
      e.last = (n == int'(len)); e.err = err;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{id: beat_id, addr: beat_addr, lane: beat_lane, idx: beat_idx, last: beat_last, err: beat_err};
    if (rst) begin
      stalled = 1'b0;
    end else if (beat_valid) begin
      if (stalled) begin
        checks++;
        if (cur !== held) begin
          fails++;
          $display("FAIL stall_hold got=%h want=%h", cur, held);
        end
      end
      if (beat_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat got=%h want=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL beat got id=%h addr=%h lane=%0d idx=%0d last=%b err=%b want id=%h addr=%h lane=%0d idx=%0d last=%b err=%b",
                     cur.id, cur.addr, cur.lane, cur.idx, cur.last, cur.err,
                     e.id, e.addr, e.lane, e.idx, e.last, e.err);
          end
        end
        pop_cyc.push_back(cyc);
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = cur;
      end
    end else if (stalled) begin
      checks++;
      fails++;
      $display("FAIL stall_drop got=valid0 want=valid1");
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    logic fired = 1'b0;
    cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3000 && !fired; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        model(id, addr, len, size, burst);
        fired = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!fired) begin
      checks++;
      fails++;
      $display("FAIL cmd_accept_timeout got=not_accepted want=accepted");
    end
  endtask

  task automatic drain();
    logic done = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !beat_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout got=pending%0d want=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (beat_valid !== 1'b0 || cmd_ready !== 1'b1 || beat_addr !== 32'h0 || beat_lane !== 3'd0 ||
        beat_idx !== 8'd0 || beat_last !== 1'b0 || beat_err !== 1'b0 || beat_id !== 4'h0) begin
      fails++;
      $display("FAIL %s got valid=%b ready=%b addr=%h lane=%0d idx=%0d last=%b err=%b id=%h want 0,1,0,0,0,0,0,0",
               tag, beat_valid, cmd_ready, beat_addr, beat_lane, beat_idx, beat_last, beat_err, beat_id);
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(4'h1, 32'h0000_1002, 8'd3, 3'd2, 2'b01);
    send(4'h2, 32'h0000_0038, 8'd3, 3'd2, 2'b10);
    send(4'h3, 32'h0000_0038, 8'd2, 3'd2, 2'b10);
    send(4'h4, 32'h0000_0100, 8'd2, 3'd3, 2'b00);
    send(4'h5, 32'h0000_0FF8, 8'd3, 3'd2, 2'b01);
    send(4'h6, 32'h0000_0200, 8'd0, 3'd1, 2'b01);
    drain();

    pop_cyc.delete();
    send(4'h7, 32'h0000_2000, 8'd1, 3'd2, 2'b01);
    send(4'h8, 32'h0000_3000, 8'd1, 3'd2, 2'b01);
    drain();
    checks++;
    if (pop_cyc.size() != 4 || pop_cyc[3] - pop_cyc[0] != 3) begin
      fails++;
      $display("FAIL back_to_back got beats=%0d span=%0d want beats=4 span=3",
               pop_cyc.size(), (pop_cyc.size() == 4) ? pop_cyc[3] - pop_cyc[0] : -1);
    end

    mode = 1;
    send(4'h9, 32'h0000_4000, 8'd7, 3'd3, 2'b01);
    send(4'hA, 32'h0000_0070, 8'd7, 3'd3, 2'b10);
    drain();
    mode = 0;
    send(4'hB, 32'h0000_0000, 8'd255, 3'd0, 2'b01);
    drain();

    mode = 1;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] len;
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 15));
      send(4'($urandom), $urandom, len, 3'($urandom_range(0, 7) == 0 ? $urandom_range(4, 7) : $urandom_range(0, 3)),
           2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();
    mode = 0;

    send(4'hC, 32'h0000_0500, 8'd7, 3'd2, 2'b01);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (beat_valid && beat_idx == 8'd2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL reach_beat2 got=not_seen want=seen");
    end
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("reset_midburst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(4'hD, 32'h0000_0600, 8'd3, 3'd2, 2'b01);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
